// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM state encoding and state-class helpers for the SPI command sequencer.
package spi_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_HOLD  = 8'h02;

  localparam int BCNT_W = 2;
  typedef logic [BCNT_W-1:0] bcnt_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    BUS  = 3'd4,
    HOLD = 3'd5
  } state_t;

  // States in which a waiting FIFO byte is popped.
  function automatic logic pops_in(state_t s);
    return s inside {IDLE, ADDR, LEN, DATA, HOLD};
  endfunction

  // States that are mid-packet and waiting on the host, so the inter-byte timer runs.
  function automatic logic times_in(state_t s);
    return s inside {ADDR, LEN, DATA, HOLD};
  endfunction

endpackage

// File: rtl/spi_cmd_timer.sv
// Inter-byte watchdog: counts run cycles since the last clr; expired pulses combinationally on the
// TIMEOUT-th idle cycle, and a clr in that same cycle suppresses it. No backpressure.
module spi_cmd_timer #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign expired = run & ~clr & (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || expired) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Drains SPI RX FIFO bytes (<=1/cycle) and executes WRITE bursts / CPU HOLD packets; a bus write
// is issued the cycle after its 4th data byte and no bytes are popped while waiting on mem_ready.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int TIMEOUT       = 100000,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_dr,
  output logic        rx_rstrb,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        cpu_hold,
  output logic        busy,
  output logic        err_proto,
  output logic        err_timeout,
  input  logic        err_clr
);

  state_t     state;
  bcnt_t      bcnt;
  logic [7:0] wcnt;
  logic       pop;
  logic       tmo_clr;
  logic       tmo_exp;

  assign pop       = rx_dr & ~reset & pops_in(state);
  assign rx_rstrb  = pop;
  assign mem_wstrb = mem_valid ? 4'hF : 4'h0;
  // Leaving BUS for DATA is an entry into a collecting state without a pop.
  assign tmo_clr   = pop | ((state == BUS) & mem_ready);

  spi_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (times_in(state)),
    .clr     (tmo_clr),
    .expired (tmo_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bcnt        <= '0;
      wcnt        <= '0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_hold    <= HOLD_AT_RESET;
      busy        <= 1'b0;
      err_proto   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_proto   <= err_proto & ~err_clr;
      err_timeout <= err_timeout & ~err_clr;
      if (tmo_exp) begin
        state       <= IDLE;
        busy        <= 1'b0;
        err_timeout <= 1'b1;
      end else begin
        case (state)
          IDLE: if (pop) begin
            if (rx_data == OP_WRITE) begin
              state <= ADDR;
              bcnt  <= '0;
              busy  <= 1'b1;
            end else if (rx_data == OP_HOLD) begin
              state <= HOLD;
              busy  <= 1'b1;
            end else begin
              err_proto <= 1'b1;
            end
          end
          ADDR: if (pop) begin
            // Big-endian address; the final byte drops the sub-word bits.
            if (bcnt == '1) begin
              mem_addr <= {mem_addr[23:0], rx_data[7:2], 2'b00};
              state    <= LEN;
            end else begin
              mem_addr <= {mem_addr[23:0], rx_data};
            end
            bcnt <= bcnt + bcnt_t'(1);
          end
          LEN: if (pop) begin
            wcnt  <= rx_data;
            bcnt  <= '0;
            state <= DATA;
          end
          DATA: if (pop) begin
            mem_wdata <= {rx_data, mem_wdata[31:8]};
            bcnt      <= bcnt + bcnt_t'(1);
            if (bcnt == '1) begin
              state     <= BUS;
              mem_valid <= 1'b1;
            end
          end
          BUS: if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_addr  <= mem_addr + 32'd4;
            bcnt      <= '0;
            if (wcnt == 8'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              wcnt  <= wcnt - 8'd1;
              state <= DATA;
            end
          end
          HOLD: if (pop) begin
            cpu_hold <= rx_data[0];
            state    <= IDLE;
            busy     <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: queue-backed RX FIFO, stalling memory responder, and packet-level
// expectations built from address/word lists.
module tb_spi_cmd_ctrl;

  localparam int TMO = 20;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_dr;
  logic        rx_rstrb;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        cpu_hold;
  logic        busy;
  logic        err_proto;
  logic        err_timeout;
  logic        err_clr;

  spi_cmd_ctrl #(.TIMEOUT(TMO), .HOLD_AT_RESET(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_dr       (rx_dr),
    .rx_rstrb    (rx_rstrb),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .err_proto   (err_proto),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0]  q[$];
  logic [7:0]  bq[$];
  logic [31:0] wr_words[$];
  wr_t         obs_q[$];
  wr_t         exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          stall = 0;
  int          wait_cnt = 0;
  int          stab_err = 0;
  logic        pend_pop = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  // FIFO + memory responder: drive at negedge, observe 4 time units later.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_pop && !reset && q.size() > 0) begin
        q.delete(0);
        last_pop_cyc = cyc;
      end
      pend_pop = 1'b0;
      if (!reset && q.size() > 0) begin
        rx_dr   = 1'b1;
        rx_data = q[0];
      end else begin
        rx_dr = 1'b0;
      end
      if (mem_valid) begin
        mem_ready = (wait_cnt >= stall);
        wait_cnt++;
      end else begin
        wait_cnt  = 0;
        mem_ready = (stall == 0);
      end
      #4;
      pend_pop = rx_rstrb;
      if (mem_valid && prev_hold && (mem_addr !== prev_addr || mem_wdata !== prev_wdata))
        stab_err++;
      prev_hold  = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      if (mem_valid && mem_ready && !reset) begin
        w.addr = mem_addr;
        w.data = mem_wdata;
        w.strb = mem_wstrb;
        obs_q.push_back(w);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    if (!reset) begin
      rx_dr   = 1'b1;
      rx_data = q[0];
    end
  endtask

  task automatic push_bq();
    foreach (bq[i]) push(bq[i]);
  endtask

  // Encode a WRITE packet from raw address + wr_words, and queue the expected bus writes.
  task automatic send_write(input logic [31:0] a);
    wr_t         w;
    logic [31:0] wd;
    push(8'h01);
    push(a[31:24]); push(a[23:16]); push(a[15:8]); push(a[7:0]);
    push(8'(wr_words.size() - 1));
    for (int i = 0; i < wr_words.size(); i++) begin
      wd = wr_words[i];
      push(wd[7:0]); push(wd[15:8]); push(wd[23:16]); push(wd[31:24]);
      w.addr = (a & 32'hFFFF_FFFC) + 32'(4 * i);
      w.data = wd;
      w.strb = 4'hF;
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_done(input string tag);
    logic done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      done = (q.size() == 0) && !busy && !mem_valid && !rx_rstrb;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
      check({tag, "_strb"}, 32'(obs_q[i].strb), 32'(exp_q[i].strb));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          t;
    logic        seen;
    logic [7:0]  v;
    logic [31:0] a;
    reset   = 1'b1;
    err_clr = 1'b0;
    rx_dr   = 1'b0;
    rx_data = 8'h00;
    mem_ready = 1'b0;
    tick();
    rx_dr   = 1'b1;
    rx_data = 8'h01;
    #1;
    check("rst_rstrb", 32'(rx_rstrb), 32'd0);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", {30'd0, err_proto, err_timeout}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single word, mem_ready tied high.
    stall = 0;
    bq = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    push_bq();
    exp_q.push_back('{32'h0000_1000, 32'h1234_5678, 4'hF});
    wait_done("t1");
    compare_writes("t1");
    check("t1_errs", {30'd0, err_proto, err_timeout}, 32'd0);

    // Two-word burst with 3-cycle stall; low address bits ignored.
    stall = 3;
    bq = '{8'h01, 8'h00, 8'h00, 8'h20, 8'h02, 8'h01,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    push_bq();
    exp_q.push_back('{32'h0000_2000, 32'h4433_2211, 4'hF});
    exp_q.push_back('{32'h0000_2004, 32'h8877_6655, 4'hF});
    wait_done("t2");
    compare_writes("t2");

    // Address wrap.
    stall = 1;
    wr_words = '{32'hCAFE_F00D, 32'h0BAD_BEEF};
    send_write(32'hFFFF_FFFF);
    wait_done("t3");
    compare_writes("t3");

    // CPU hold control.
    bq = '{8'h02, 8'h00};
    push_bq();
    wait_done("t4a");
    check("t4_release", 32'(cpu_hold), 32'd0);
    bq = '{8'h02, 8'h03};
    push_bq();
    wait_done("t4b");
    check("t4_hold", 32'(cpu_hold), 32'd1);

    // Unknown opcode.
    push(8'h7E);
    wait_done("t5p");
    check("t5_proto", 32'(err_proto), 32'd1);
    check("t5_proto_busy", 32'(busy), 32'd0);

    // Inter-byte timeout: still busy on the last counting cycle, aborted one cycle later.
    push(8'h01);
    push(8'h00);
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    t = last_pop_cyc;
    for (int i = 0; i < 4 * TMO && cyc < t + TMO - 1; i++) tick();
    check("tmo_pre_busy", 32'(busy), 32'd1);
    check("tmo_pre_err", 32'(err_timeout), 32'd0);
    tick();
    check("tmo_err", 32'(err_timeout), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_nowr", 32'(obs_q.size()), 32'd0);
    check("tmo_proto_sticky", 32'(err_proto), 32'd1);

    // err_clr with a simultaneous bad opcode: set wins for err_proto.
    push(8'h7E);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check("clr_setwins", 32'(err_proto), 32'd1);
    check("clr_tmo", 32'(err_timeout), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check("clr_proto", 32'(err_proto), 32'd0);

    // A byte arriving on the expiry cycle is accepted.
    stall = 0;
    push(8'h01); push(8'h00); push(8'h00);
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    t = last_pop_cyc;
    for (int i = 0; i < 4 * TMO && cyc < t + TMO - 1; i++) tick();
    bq = '{8'h50, 8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    push_bq();
    exp_q.push_back('{32'h0000_5000, 32'hD4C3_B2A1, 4'hF});
    wait_done("late");
    compare_writes("late");
    check("late_tmo", 32'(err_timeout), 32'd0);

    // Reset while a bus cycle is stalled.
    bq = '{8'h02, 8'h00};
    push_bq();
    wait_done("t6h");
    stall = 100000;
    bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_bq();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = mem_valid;
    end
    check("t6_valid", 32'(seen), 32'd1);
    check("t6_addr", mem_addr, 32'h0000_0080);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(mem_valid), 32'd0);
    check("t6_rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_hold", 32'(cpu_hold), 32'd1);
    q.delete();
    rx_dr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    stall = 0;
    tick();
    bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    push_bq();
    exp_q.push_back('{32'h0000_0040, 32'h0403_0201, 4'hF});
    wait_done("t6");
    compare_writes("t6");

    // Randomized packets against the packet-level model.
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = 8'($urandom_range(0, 255));
        push(8'h02);
        push(v);
        wait_done("rnd_h");
        check("rnd_hold", 32'(cpu_hold), 32'(v[0]));
      end else begin
        a = $urandom;
        if (k == 3) a = 32'hFFFF_FFF8 | (a & 32'h3);
        stall = $urandom_range(0, 3);
        wr_words.delete();
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) wr_words.push_back($urandom);
        send_write(a);
        wait_done("rnd_w");
        compare_writes("rnd_w");
      end
    end
    check("rnd_errs", {30'd0, err_proto, err_timeout}, 32'd0);
    check("stable_while_stalled", 32'(stab_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
